pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register, the successor to the fixed IF/ID register. It carries PC, PC+4, the instruction word and an optional sideband payload, plus an explicit valid bit. It supports stall (en low), flush with a selectable priority mode and NOP bubble injection, and it keeps saturating per-stage event counters for perf and debug. One instance is placed at each stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB), with widths set per boundary.

---
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register placed at every stage
// boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries PC, PC+4, instruction,
// sideband and an explicit valid bit. Supports stall (en low), flush with a
// selectable priority mode, NOP bubble injection, and saturating per-stage
// event counters for perf/debug.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   en           in   stage enable; 0 = stall (hold contents)
//   flush        in   squash the stage contents
//   valid_in     in   upstream slot holds a real instruction
//   instr_in     in   [ILEN]   instruction from previous stage
//   pc_in        in   [XLEN]   PC from previous stage
//   pcplus4_in   in   [XLEN]   PC+4 from previous stage
//   side_in      in   [SIDE_W] sideband from previous stage
//   cnt_clr      in   synchronous clear of all event counters
//   instr_out    out  [ILEN]   registered instruction
//   pc_out       out  [XLEN]   registered PC
//   pcplus4_out  out  [XLEN]   registered PC+4
//   side_out     out  [SIDE_W] registered sideband
//   valid_out    out  registered valid
//   stall_cnt    out  [CNT_W]  cycles stalled with no flush applied
//   flush_cnt    out  [CNT_W]  cycles in which a flush was applied
//   bubble_cnt   out  [CNT_W]  cycles loading a bubble
module pipe_stage_reg #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     ILEN       = 32,
  parameter int unsigned     SIDE_W     = 1,
  parameter logic [ILEN-1:0] NOP_INSTR  = ILEN'(32'h13),
  parameter bit              FLUSH_MODE = 1'b1,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [ILEN-1:0]   instr_in,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   pcplus4_in,
  input  logic [SIDE_W-1:0] side_in,
  input  logic              cnt_clr,
  output logic [ILEN-1:0]   instr_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   pcplus4_out,
  output logic [SIDE_W-1:0] side_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Stage payload held in the register.
  typedef struct packed {
    logic [ILEN-1:0]   instr;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pcplus4;
    logic [SIDE_W-1:0] side;
    logic              valid;
  } stage_t;

  localparam stage_t BUBBLE = '{
    instr:   NOP_INSTR,
    pc:      '0,
    pcplus4: '0,
    side:    '0,
    valid:   1'b0
  };

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_t q;
  stage_t q_next_c;

  logic flush_apply_c;
  logic stall_evt_c;
  logic bubble_evt_c;

  // Saturating increment: sticks at all-ones, never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Event decode. With FLUSH_MODE=0 a flush during a stall is simply dropped.
  always_comb begin
    flush_apply_c = flush & (en | FLUSH_MODE);
    stall_evt_c   = ~en & ~flush_apply_c;
    bubble_evt_c  = flush_apply_c | (en & ~valid_in);
  end

  // Next payload: bubble on flush, load on enable (scrubbing invalid slots
  // so valid=0 always implies NOP/zero sideband), otherwise hold.
  always_comb begin
    q_next_c = q;
    if (flush_apply_c) begin
      q_next_c = BUBBLE;
    end else if (en) begin
      q_next_c.pc      = pc_in;
      q_next_c.pcplus4 = pcplus4_in;
      q_next_c.valid   = valid_in;
      if (valid_in) begin
        q_next_c.instr = instr_in;
        q_next_c.side  = side_in;
      end else begin
        q_next_c.instr = NOP_INSTR;
        q_next_c.side  = '0;
      end
    end
  end

  // Payload register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= BUBBLE;
    end else begin
      q <= q_next_c;
    end
  end

  // Event counters; clear wins over any increment in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall_evt_c) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (flush_apply_c) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
      if (bubble_evt_c) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end

  assign instr_out   = q.instr;
  assign pc_out      = q.pc;
  assign pcplus4_out = q.pcplus4;
  assign side_out    = q.side;
  assign valid_out   = q.valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. Three instances share one stimulus stream:
//   u0: defaults, FLUSH_MODE=0
//   u1: FLUSH_MODE=1, CNT_W=4 (saturation)
//   u2: XLEN=64, SIDE_W=8, FLUSH_MODE=1 (wide fields)
// A per-instance behavioural model is stepped on each clock and compared
// against every instance after each edge, plus directed literal checks.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, flush, valid_in, cnt_clr;
  logic [31:0] instr_in;
  logic [63:0] pc_in, pcplus4_in;
  logic [7:0]  side_in;

  always #5 clk = ~clk;

  logic [31:0] o0_instr, o0_pc, o0_pc4;
  logic [0:0]  o0_side;
  logic        o0_valid;
  logic [15:0] o0_sc, o0_fc, o0_bc;

  logic [31:0] o1_instr, o1_pc, o1_pc4;
  logic [0:0]  o1_side;
  logic        o1_valid;
  logic [3:0]  o1_sc, o1_fc, o1_bc;

  logic [31:0] o2_instr;
  logic [63:0] o2_pc, o2_pc4;
  logic [7:0]  o2_side;
  logic        o2_valid;
  logic [15:0] o2_sc, o2_fc, o2_bc;

  pipe_stage_reg #(.FLUSH_MODE(1'b0)) u0 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .pc_in(pc_in[31:0]), .pcplus4_in(pcplus4_in[31:0]),
    .side_in(side_in[0:0]), .cnt_clr(cnt_clr),
    .instr_out(o0_instr), .pc_out(o0_pc), .pcplus4_out(o0_pc4),
    .side_out(o0_side), .valid_out(o0_valid),
    .stall_cnt(o0_sc), .flush_cnt(o0_fc), .bubble_cnt(o0_bc));

  pipe_stage_reg #(.FLUSH_MODE(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .pc_in(pc_in[31:0]), .pcplus4_in(pcplus4_in[31:0]),
    .side_in(side_in[0:0]), .cnt_clr(cnt_clr),
    .instr_out(o1_instr), .pc_out(o1_pc), .pcplus4_out(o1_pc4),
    .side_out(o1_side), .valid_out(o1_valid),
    .stall_cnt(o1_sc), .flush_cnt(o1_fc), .bubble_cnt(o1_bc));

  pipe_stage_reg #(.XLEN(64), .SIDE_W(8), .FLUSH_MODE(1'b1)) u2 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .valid_in(valid_in),
    .instr_in(instr_in), .pc_in(pc_in), .pcplus4_in(pcplus4_in),
    .side_in(side_in), .cnt_clr(cnt_clr),
    .instr_out(o2_instr), .pc_out(o2_pc), .pcplus4_out(o2_pc4),
    .side_out(o2_side), .valid_out(o2_valid),
    .stall_cnt(o2_sc), .flush_cnt(o2_fc), .bubble_cnt(o2_bc));

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance.
  logic [31:0] m_instr [3];
  logic [63:0] m_pc    [3];
  logic [63:0] m_pc4   [3];
  logic [7:0]  m_side  [3];
  logic        m_valid [3];
  int unsigned m_sc [3];
  int unsigned m_fc [3];
  int unsigned m_bc [3];

  function automatic bit inst_mode(input int k);
    return (k != 0);
  endfunction

  function automatic int unsigned inst_cmax(input int k);
    return (k == 1) ? 15 : 65535;
  endfunction

  function automatic logic [63:0] inst_pcmask(input int k);
    return (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [7:0] inst_sidemask(input int k);
    return (k == 2) ? 8'hFF : 8'h01;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_instr[k] = NOP;
      m_pc[k]    = '0;
      m_pc4[k]   = '0;
      m_side[k]  = '0;
      m_valid[k] = 1'b0;
      m_sc[k] = 0;
      m_fc[k] = 0;
      m_bc[k] = 0;
    end
  endtask

  function automatic int unsigned bump(input int unsigned v, input int unsigned mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // One clock of the architectural rules for every instance.
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit fa;
      fa = flush && (en || inst_mode(k));
      if (cnt_clr) begin
        m_sc[k] = 0;
        m_fc[k] = 0;
        m_bc[k] = 0;
      end else begin
        if (!en && !fa) m_sc[k] = bump(m_sc[k], inst_cmax(k));
        if (fa) m_fc[k] = bump(m_fc[k], inst_cmax(k));
        if (fa || (en && !valid_in)) m_bc[k] = bump(m_bc[k], inst_cmax(k));
      end
      if (fa) begin
        m_instr[k] = NOP;
        m_pc[k] = '0;
        m_pc4[k] = '0;
        m_side[k] = '0;
        m_valid[k] = 1'b0;
      end else if (en) begin
        m_pc[k]    = pc_in & inst_pcmask(k);
        m_pc4[k]   = pcplus4_in & inst_pcmask(k);
        m_valid[k] = valid_in;
        m_instr[k] = valid_in ? instr_in : NOP;
        m_side[k]  = valid_in ? (side_in & inst_sidemask(k)) : 8'h00;
      end
    end
  endtask

  task automatic check_inst(input int k, input logic [31:0] ins, input logic [63:0] pc,
                            input logic [63:0] pc4, input logic [7:0] sd, input logic v,
                            input logic [15:0] sc, input logic [15:0] fc, input logic [15:0] bc);
    check($sformatf("u%0d.instr", k), 64'(ins), 64'(m_instr[k]));
    check($sformatf("u%0d.pc", k), pc, m_pc[k]);
    check($sformatf("u%0d.pcplus4", k), pc4, m_pc4[k]);
    check($sformatf("u%0d.side", k), 64'(sd), 64'(m_side[k]));
    check($sformatf("u%0d.valid", k), 64'(v), 64'(m_valid[k]));
    check($sformatf("u%0d.stall_cnt", k), 64'(sc), 64'(m_sc[k]));
    check($sformatf("u%0d.flush_cnt", k), 64'(fc), 64'(m_fc[k]));
    check($sformatf("u%0d.bubble_cnt", k), 64'(bc), 64'(m_bc[k]));
  endtask

  task automatic check_all();
    check_inst(0, o0_instr, 64'(o0_pc), 64'(o0_pc4), 8'(o0_side), o0_valid, o0_sc, o0_fc, o0_bc);
    check_inst(1, o1_instr, 64'(o1_pc), 64'(o1_pc4), 8'(o1_side), o1_valid,
               16'(o1_sc), 16'(o1_fc), 16'(o1_bc));
    check_inst(2, o2_instr, o2_pc, o2_pc4, o2_side, o2_valid, o2_sc, o2_fc, o2_bc);
  endtask

  // Clock edge, step model, sample 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic e, input logic f, input logic v, input logic [31:0] ins,
                       input logic [63:0] pc, input logic [7:0] sd, input logic clr);
    en = e; flush = f; valid_in = v; instr_in = ins;
    pc_in = pc; pcplus4_in = pc + 64'd4; side_in = sd; cnt_clr = clr;
  endtask

  // Async reset asserted mid-cycle; outputs must clear with no clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    check("rst.u0.instr", 64'(o0_instr), 64'(NOP));
    check("rst.u0.valid", 64'(o0_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0);
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-run while a valid instruction is held.
    drive(1'b1, 1'b0, 1'b1, 32'h00A0_0093, 64'h40, 8'h1, 1'b0);
    cycle();
    check("t1.pre.valid", 64'(o0_valid), 64'd1);
    check("t1.pre.instr", 64'(o0_instr), 64'h00A0_0093);
    do_reset();
    check("t1.u2.pc", o2_pc, 64'd0);
    check("t1.u0.bubble_cnt", 64'(o0_bc), 64'd0);

    // Load then stall 3 cycles with changing inputs.
    drive(1'b1, 1'b0, 1'b1, 32'h0050_0113, 64'h100, 8'h1, 1'b0);
    cycle();
    check("t2.load.pc4", 64'(o0_pc4), 64'h104);
    check("t2.load.side", 64'(o0_side), 64'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, $urandom, {32'h0, $urandom}, 8'($urandom), 1'b0);
      cycle();
    end
    check("t2.hold.instr", 64'(o0_instr), 64'h0050_0113);
    check("t2.hold.pc", 64'(o0_pc), 64'h100);
    check("t2.stall_cnt", 64'(o0_sc), 64'd3);

    // Flush during stall: dropped in mode 0, applied in mode 1.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h00A0_0093, 64'h300, 8'h1, 1'b0);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 32'h1234_5678, 64'h500, 8'h1, 1'b0);
    cycle();
    check("t3.m1.instr", 64'(o1_instr), 64'(NOP));
    check("t3.m1.pc", 64'(o1_pc), 64'd0);
    cycle();
    check("t3.m0.instr", 64'(o0_instr), 64'h00A0_0093);
    check("t3.m0.flush_cnt", 64'(o0_fc), 64'd0);
    check("t3.m0.stall_cnt", 64'(o0_sc), 64'd2);
    check("t3.m1.flush_cnt", 64'(o1_fc), 64'd2);
    check("t3.m1.bubble_cnt", 64'(o1_bc), 64'd2);
    check("t3.m1.stall_cnt", 64'(o1_sc), 64'd0);

    // Invalid slot while enabled becomes a bubble but keeps pc.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 64'h200, 8'hFF, 1'b0);
    cycle();
    check("t4.instr", 64'(o0_instr), 64'(NOP));
    check("t4.side", 64'(o2_side), 64'd0);
    check("t4.pc", 64'(o0_pc), 64'h200);
    check("t4.valid", 64'(o0_valid), 64'd0);
    check("t4.bubble_cnt", 64'(o0_bc), 64'd1);

    // Saturation at 15 on the 4-bit instance, then clear priority.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'($urandom), $urandom, 64'h0, 8'h0, 1'b0);
      cycle();
    end
    check("t5.sat", 64'(o1_sc), 64'd15);
    check("t5.u0", 64'(o0_sc), 64'd20);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b1);
    cycle();
    check("t5.clr", 64'(o1_sc), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0, 1'b0);
    cycle();
    check("t5.after_clr", 64'(o1_sc), 64'd1);

    // Wide PC and sideband captured and then flushed.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h0050_0113, 64'hFFFF_FFFF_0000_0004, 8'hA5, 1'b0);
    cycle();
    check("t6.pc64", o2_pc, 64'hFFFF_FFFF_0000_0004);
    check("t6.side8", 64'(o2_side), 64'hA5);
    check("t6.pc32", 64'(o0_pc), 64'h4);
    drive(1'b1, 1'b1, 1'b1, 32'h0050_0113, 64'hFFFF_FFFF_0000_0004, 8'hA5, 1'b0);
    cycle();
    check("t6.flush.pc64", o2_pc, 64'd0);
    check("t6.flush.side8", 64'(o2_side), 64'd0);

    // Randomised traffic with occasional async reset.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 1'($urandom),
            $urandom, {$urandom, $urandom}, 8'($urandom), ($urandom_range(0, 63) == 0));
      cycle();
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
